uart_cfg_arbiter: RTL
=====================

Name: uart_cfg_arbiter

Overview:
Shares the UART configuration-register bus (baud/parity/stop-bits, 2-bit address, 32-bit data) between two requesters: port 0 (host CPU) and port 1 (auto-baud/boot loader).
- Arbitrates round-robin and sequences one transaction at a time.
- Holds config writes until the UART link is idle, so framing never changes mid-character.
- Returns a one-cycle response with read data or error.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles a write waits for link idle before aborting with error (≥2)
CNT_W, $clog2(TIMEOUT_CYCLES), width of the wait counter

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  port-0 request present
req0_ready  out  1  port-0 request accepted this cycle
req0_write  in  1  1=write, 0=read
req0_addr  in  2  register address
req0_wdata  in  32  write data
rsp0_valid  out  1  port-0 response, one-cycle pulse
rsp0_rdata  out  32  read data (0 on write or error)
rsp0_err  out  1  error flag, valid with rsp0_valid
req1_valid, req1_ready, req1_write, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err  —  same as port 0, for port 1
link_busy  in  1  UART TX or RX frame in progress
cfg_wr_en  out  1  config-register write strobe
cfg_addr  out  2  config-register address
cfg_wr_data  out  32  config-register write data
cfg_rd_data  in  32  config-register read data (combinational from cfg_addr)
grant_id  out  1  port owning current transaction (valid when not IDLE)

Behaviour:
- FSM states: IDLE, WAIT_IDLE, ACCESS, RESP. Exactly one transaction in flight; no pipelining.
- Reset (rst=1 at edge):
  - state=IDLE; rr pointer favours port 0; wait counter=0.
  - All outputs 0: reqX_ready, rspX_valid, rspX_rdata, rspX_err, cfg_wr_en, cfg_addr, cfg_wr_data, grant_id.
  - Reset mid-transaction drops it silently: no response, no write.
- IDLE:
  - If any reqX_valid, grant one port.
    - Both valid: grant the port opposite the last granted. Pointer flips after each grant.
    - One valid: grant it; pointer still updates.
  - req_ready for the granted port is asserted combinationally in this same cycle. The other port's ready stays 0.
  - On that edge, latch write/addr/wdata/port.
  - Next state:
    - addr==3 (unmapped): RESP with err.
    - Write: WAIT_IDLE.
    - Read: ACCESS.
- WAIT_IDLE:
  - If link_busy==0: go to ACCESS, clear counter.
  - Else increment counter. If counter==TIMEOUT_CYCLES-1 while link_busy==1: go to RESP with err=1 and no write. Counter clears.
- ACCESS, one cycle:
  - cfg_addr = latched addr.
  - Write: cfg_wr_en=1, cfg_wr_data = latched wdata.
  - Read: cfg_wr_en=0; capture cfg_rd_data into the response register.
  - Next state: RESP.
- RESP, one cycle:
  - rspX_valid=1 for the granted port only, with rdata/err.
  - No backpressure; requester must accept.
  - Next state: IDLE. A new grant is possible in the following cycle.
- Output hold rules:
  - cfg_addr holds the latched address in WAIT_IDLE/ACCESS/RESP and is 0 in IDLE.
  - cfg_wr_en is high only in ACCESS for a write.
  - cfg_wr_data is 0 except in ACCESS for a write.
- Latency from accept edge T:
  - Read: rsp_valid at T+2.
  - Write with link idle: cfg_wr_en at T+2, rsp_valid at T+3.
  - Unmapped: rsp_valid at T+1.
- link_busy is ignored for reads.
- A request held valid is not re-accepted while the arbiter is non-IDLE.
- rspX_rdata=0 for writes and for errors.

Test Plan:
- Read addr 0 on port 0, link idle, cfg_rd_data=115200 → req0_ready at T, rsp0_valid at T+2, rdata=115200, err=0; cfg_wr_en never high.
- Write addr 1, wdata=3, on port 1 with link_busy=0 → cfg_wr_en one cycle at T+2 with cfg_addr=1, cfg_wr_data=3; rsp1_valid at T+3, err=0.
- Both ports valid every cycle, 4 transactions → grants 0,1,0,1; each rsp on the matching port; no overlap.
- Write addr 2 with link_busy=1 for 10 cycles then 0 (TIMEOUT_CYCLES=16) → no write until link_busy falls; then a single cfg_wr_en pulse and rsp err=0. Repeat with link_busy held 1 → rsp err=1 after 16 wait cycles, cfg_wr_en never asserted.
- Request addr 3 → rsp at T+1, err=1, rdata=0, no cfg_wr_en.
- Assert rst during WAIT_IDLE → next cycle all outputs 0, no response; next request is granted to port 0 first.

Source files
------------

// File: rtl/uart_cfg_arbiter.sv
// Round-robin arbiter sharing the UART configuration-register bus between two requesters.
// Config writes are held until the link is idle so framing never changes mid-character.
module uart_cfg_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [1:0]  req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [1:0]  req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,

    input  logic        link_busy,
    output logic        cfg_wr_en,
    output logic [1:0]  cfg_addr,
    output logic [31:0] cfg_wr_data,
    input  logic [31:0] cfg_rd_data,
    output logic        grant_id
);

    // Handshake: a request transfers on a rising edge where valid and ready are both high.
    // Ready is only ever raised in IDLE, for the single port chosen that cycle.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        ACCESS    = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_next;
    logic              prio, prio_next;       // port that wins when both request
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              wr_q, wr_next;
    logic              port_q, port_next;
    logic              err_q, err_next;
    logic [1:0]        addr_q, addr_next;
    logic [31:0]       wdata_q, wdata_next;
    logic [31:0]       rdata_q, rdata_next;

    logic              sel;
    logic              sel_write;
    logic [1:0]        sel_addr;
    logic [31:0]       sel_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prio    <= 1'b0;
            cnt     <= '0;
            wr_q    <= 1'b0;
            port_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 2'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state   <= state_next;
            prio    <= prio_next;
            cnt     <= cnt_next;
            wr_q    <= wr_next;
            port_q  <= port_next;
            err_q   <= err_next;
            addr_q  <= addr_next;
            wdata_q <= wdata_next;
            rdata_q <= rdata_next;
        end
    end

    always_comb begin
        state_next = state;
        prio_next  = prio;
        cnt_next   = cnt;
        wr_next    = wr_q;
        port_next  = port_q;
        err_next   = err_q;
        addr_next  = addr_q;
        wdata_next = wdata_q;
        rdata_next = rdata_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        sel       = (req0_valid && req1_valid) ? prio : req1_valid;
        sel_write = sel ? req1_write : req0_write;
        sel_addr  = sel ? req1_addr  : req0_addr;
        sel_wdata = sel ? req1_wdata : req0_wdata;

        case (state)
            IDLE: begin
                // No handshake is offered while reset is asserted, so nothing is lost across it.
                if (!rst && (req0_valid || req1_valid)) begin
                    req0_ready = ~sel;
                    req1_ready = sel;
                    prio_next  = ~sel;
                    port_next  = sel;
                    wr_next    = sel_write;
                    addr_next  = sel_addr;
                    wdata_next = sel_wdata;
                    rdata_next = 32'd0;
                    cnt_next   = '0;
                    if (sel_addr == 2'd3) begin
                        err_next   = 1'b1;
                        state_next = RESP;
                    end else begin
                        err_next   = 1'b0;
                        state_next = sel_write ? WAIT_IDLE : ACCESS;
                    end
                end
            end
            WAIT_IDLE: begin
                if (!link_busy) begin
                    cnt_next   = '0;
                    state_next = ACCESS;
                end else if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ACCESS: begin
                if (!wr_q) rdata_next = cfg_rd_data;
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cfg_addr    = (state != IDLE) ? addr_q : 2'd0;
        cfg_wr_en   = (state == ACCESS) && wr_q;
        cfg_wr_data = cfg_wr_en ? wdata_q : 32'd0;
        grant_id    = (state != IDLE) && port_q;
        rsp0_valid  = (state == RESP) && !port_q;
        rsp1_valid  = (state == RESP) && port_q;
        rsp0_rdata  = rsp0_valid ? rdata_q : 32'd0;
        rsp1_rdata  = rsp1_valid ? rdata_q : 32'd0;
        rsp0_err    = rsp0_valid && err_q;
        rsp1_err    = rsp1_valid && err_q;
    end

endmodule
